// File: rtl/mem_fill_pkg.sv
// Shared types and constants for the block-fill memory responder.
package mem_fill_pkg;

    localparam int LATENCY_DEF         = 4;
    localparam int WORDS_PER_BLOCK_DEF = 8;
    localparam int BLOCK_OFFSET_BITS   = 4;
    localparam int ADDR_W_DEF          = 16;
    localparam int DATA_W_DEF          = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } fill_state_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
        logic                  last;
    } rsp_entry_t;

endpackage

// File: rtl/mem_fill_responder_pipe.sv
// Fixed-depth shift register of response entries; the last stage drives the response port.
module mem_latency_pipe
    import mem_fill_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  rsp_entry_t push,
    output rsp_entry_t head,
    output logic       empty,
    output logic       empty_next
);

    rsp_entry_t stage [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= push;
            for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    assign head = stage[LATENCY-1];

    // empty_next: nothing upstream of the head, so the pipe is empty after the next edge
    always_comb begin
        empty      = 1'b1;
        empty_next = !push.valid;
        for (int i = 0; i < LATENCY; i++) begin
            if (stage[i].valid) empty = 1'b0;
            if (stage[i].valid && (i < LATENCY - 1)) empty_next = 1'b0;
        end
    end

endmodule

// File: rtl/mem_fill_responder.sv
// Main-memory responder: 8-word block fills through a fixed-latency pipe, single-word writes.
module mem_fill_responder
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int LATENCY         = LATENCY_DEF,
    parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
    parameter int MEM_WORDS       = 32768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_last,
    output logic              wr_ack,
    output logic              busy
);

    localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int LAT_W = $clog2(LATENCY + 1);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    fill_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] base;
    logic [LAT_W-1:0]  wcnt;
    logic              ack_q;

    rsp_entry_t        push;
    rsp_entry_t        head;
    logic              pipe_empty;
    logic              pipe_empty_next;
    logic              accept;
    logic [ADDR_W-1:0] issue_addr;
    logic [IDX_W-1:0]  issue_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              unused_addr_bit;

    assign req_ready  = (state == IDLE) && pipe_empty;
    assign accept     = req_valid && req_ready;

    // Block offset is OR-ed in, so a block never carries into the upper address bits
    assign issue_addr = base | (ADDR_W'(cnt) << 1);
    assign issue_idx  = IDX_W'(issue_addr >> 1);
    assign wr_idx     = IDX_W'(req_addr >> 1);
    assign unused_addr_bit = req_addr[0];

    always_comb begin
        push = '0;
        if (state == ISSUE) begin
            push.valid = 1'b1;
            push.addr  = issue_addr;
            push.data  = mem[issue_idx];
            push.last  = (cnt == CNT_W'(WORDS_PER_BLOCK - 1));
        end
    end

    // Storage is deliberately not reset; a write commits on its accept edge
    always_ff @(posedge clk) begin
        if (!rst && accept && req_write) mem[wr_idx] <= req_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            base  <= '0;
            wcnt  <= '0;
            ack_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_write) begin
                            wcnt  <= LAT_W'(LATENCY - 1);
                            state <= WRITE;
                        end else begin
                            base  <= {req_addr[ADDR_W-1:BLOCK_OFFSET_BITS], BLOCK_OFFSET_BITS'(0)};
                            cnt   <= '0;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WORDS_PER_BLOCK - 1)) state <= DRAIN;
                end
                DRAIN: begin
                    if (pipe_empty_next) state <= IDLE;
                end
                WRITE: begin
                    if (wcnt == '0) begin
                        ack_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wcnt <= wcnt - LAT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_latency_pipe #(.LATENCY(LATENCY)) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .head       (head),
        .empty      (pipe_empty),
        .empty_next (pipe_empty_next)
    );

    assign rsp_valid = head.valid;
    assign rsp_data  = head.data;
    assign rsp_addr  = head.addr;
    assign rsp_last  = head.last;
    assign wr_ack    = ack_q;
    assign busy      = (state != IDLE) || !pipe_empty;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Randomised scoreboard bench for mem_fill_responder against a word-array reference model.
module tb_mem_fill_responder;

    localparam int LAT = 4;
    localparam int WPB = 8;
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [15:0] rsp_addr;
    logic        rsp_last;
    logic        wr_ack;
    logic        busy;

    mem_fill_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_last  (rsp_last),
        .wr_ack    (wr_ack),
        .busy      (busy)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    // entry: [49:34] cycle, [33] data known, [32] last, [31:16] addr, [15:0] data
    logic [49:0] exp_q[$];
    int          ack_q[$];
    logic [15:0] mm [int];
    int          free_cyc = 0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic [49:0] mon_e;
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            check("req_ready", 32'(req_ready), 32'(cyc >= free_cyc));
            check("busy", 32'(busy), 32'(cyc < free_cyc));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_addr), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_cycle", 32'(cyc), 32'(mon_e[49:34]));
                    check("rsp_addr", 32'(rsp_addr), 32'(mon_e[31:16]));
                    check("rsp_last", 32'(rsp_last), 32'(mon_e[32]));
                    if (mon_e[33]) check("rsp_data", 32'(rsp_data), 32'(mon_e[15:0]));
                end
            end else begin
                check("idle_addr_data", {rsp_addr, rsp_data}, 32'h0);
                check("idle_last", 32'(rsp_last), 32'h0);
            end
            while (exp_q.size() > 0) begin
                mon_e = exp_q[0];
                if (int'(mon_e[49:34]) >= cyc) break;
                check("missed_rsp", 32'(cyc), 32'(mon_e[49:34]));
                void'(exp_q.pop_front());
            end
            if (wr_ack) begin
                if (ack_q.size() == 0) check("unexpected_ack", 32'(cyc), 32'hFFFF_FFFF);
                else check("ack_cycle", 32'(cyc), 32'(ack_q.pop_front()));
            end else if (ack_q.size() > 0 && ack_q[0] < cyc) begin
                check("missed_ack", 32'(cyc), 32'(ack_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                          input bit hold, output int hs, output int acc);
        int n;
        logic [15:0] b;
        logic [15:0] a;
        logic [49:0] e;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (n >= TIMEOUT) begin
            check("accept_timeout", 32'(n), 32'(0));
            req_valid = 1'b0;
            hs = -1;
            acc = -1;
            return;
        end
        hs = cyc;
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        if (wr) begin
            mm[int'(addr[15:1])] = wd;
            ack_q.push_back(acc + LAT);
            free_cyc = acc + LAT;
        end else begin
            b = addr & 16'hFFF0;
            for (int i = 0; i < WPB; i++) begin
                a = b | 16'(2 * i);
                e = '0;
                e[49:34] = 16'(acc + i + LAT);
                e[33]    = mm.exists(int'(a[15:1]));
                e[32]    = (i == WPB - 1);
                e[31:16] = a;
                e[15:0]  = e[33] ? mm[int'(a[15:1])] : 16'h0;
                exp_q.push_back(e);
            end
            free_cyc = acc + WPB + LAT;
        end
        if (!hold) begin
            req_valid = 1'b0;
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 16'($urandom);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_write = 1'($urandom_range(0, 1));
            req_wdata = 16'($urandom);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        exp_q.delete();
        ack_q.delete();
        free_cyc = 0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_last", 32'(rsp_last), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wr_ack", 32'(wr_ack), 32'h0);
        check("rst_rsp_addr_data", {rsp_addr, rsp_data}, 32'h0);
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int hs, acc, hs2, acc2;
    initial begin
        @(negedge clk);
        do_reset(2);

        // preloaded block read from a mid-block address
        for (int i = 0; i < WPB; i++) do_req(1'b1, 16'(16'h0040 + 2 * i), 16'(16'hA000 + i), 1'b0, hs, acc);
        do_req(1'b0, 16'h0046, 16'h0, 1'b0, hs, acc);
        idle(2);

        // write then read-back at offset 1
        do_req(1'b1, 16'h1232, 16'hBEEF, 1'b0, hs, acc);
        do_req(1'b0, 16'h1230, 16'h0, 1'b0, hs, acc);

        // second read held on the bus for the whole first block
        do_req(1'b0, 16'h0046, 16'h0, 1'b1, hs, acc);
        do_req(1'b0, 16'h2000, 16'h0, 1'b0, hs2, acc2);
        check("holdoff_accept_cycle", 32'(hs2), 32'(acc + WPB + LAT));
        idle(16);

        // reset in the middle of a block; committed write survives
        do_req(1'b1, 16'h3002, 16'h5555, 1'b0, hs, acc);
        do_req(1'b0, 16'h0040, 16'h0, 1'b0, hs, acc);
        repeat (6) @(negedge clk);
        do_reset(2);
        idle(20);
        do_req(1'b0, 16'h3000, 16'h0, 1'b0, hs, acc);

        // top-of-memory block, no wrap past 0xFFFE
        for (int i = 0; i < WPB; i++) do_req(1'b1, 16'(16'hFFF0 + 2 * i), 16'($urandom), 1'b0, hs, acc);
        do_req(1'b0, 16'hFFFA, 16'h0, 1'b0, hs, acc);

        // randomised mix in a small window so reads hit written words
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_req(1'b1, 16'($urandom_range(0, 255)), 16'($urandom), 1'b0, hs, acc);
            else
                do_req(1'b0, 16'($urandom_range(0, 255)), 16'h0, 1'b0, hs, acc);
            idle($urandom_range(0, 3));
        end

        for (int n = 0; n < TIMEOUT && (exp_q.size() > 0 || ack_q.size() > 0); n++) @(negedge clk);
        idle(2);
        check("queues_drained", 32'(exp_q.size() + ack_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
